// File: rtl/warp_scheduler.sv
// warp_scheduler
//   Launches one thread block per core and sequences its warps through the
//   shared instruction pipeline, one instruction per warp turn, round-robin.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   start             launch pulse, accepted only while idle
//   block_id          block index, latched on an accepted start
//   block_size        thread count of the block, latched on an accepted start
//   busy              a block is in progress
//   done              one-cycle pulse once every warp has retired
//   warp_enable       one-hot selected warp during FETCH..UPDATE, else zero
//   active_warp       index of the selected warp
//   warp_state        pipeline stage of the selected warp (IDLE outside stages)
//   thread_enable     execution mask of the selected warp
//   fetch_req         instruction fetch request (FETCH stage)
//   fetch_pc          PC of the selected warp
//   fetch_valid       fetched instruction ready (sampled in FETCH)
//   mem_req           instruction uses the LSU (sampled at end of DECODE)
//   lsu_done          LSU finished (sampled in WAIT)
//   instr_ret         instruction is RET (sampled at end of DECODE)
//   next_pc           PC of the selected warp after this instruction (UPDATE)

module warp_scheduler #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [31:0]                  block_id,
    input  logic [31:0]                  block_size,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_WARPS-1:0]         warp_enable,
    output logic [$clog2(NUM_WARPS)-1:0] active_warp,
    output logic [2:0]                   warp_state,
    output logic [THREADS_PER_WARP-1:0]  thread_enable,
    output logic                         fetch_req,
    output logic [31:0]                  fetch_pc,
    input  logic                         fetch_valid,
    input  logic                         mem_req,
    input  logic                         lsu_done,
    input  logic                         instr_ret,
    input  logic [31:0]                  next_pc
);

    localparam int          WARP_W   = $clog2(NUM_WARPS);
    localparam int          TPW_LOG  = $clog2(THREADS_PER_WARP);
    localparam logic [31:0] TPW_MASK = 32'(THREADS_PER_WARP - 1);

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_FETCH   = 3'd1,
        W_DECODE  = 3'd2,
        W_REQUEST = 3'd3,
        W_WAIT    = 3'd4,
        W_EXECUTE = 3'd5,
        W_UPDATE  = 3'd6,
        W_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FETCH,
        S_DECODE,
        S_REQUEST,
        S_WAIT,
        S_EXECUTE,
        S_UPDATE
    } ctrl_state_t;

    ctrl_state_t           state_q, state_d;
    logic [WARP_W-1:0]     active_q, active_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           block_id_q, block_id_d;
    logic [31:0]           block_size_q, block_size_d;
    logic [31:0]           pc_q [NUM_WARPS];
    logic [31:0]           pc_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]  wdone_q, wdone_d;
    logic                  mem_q, mem_d;
    logic                  ret_q, ret_d;

    // Warp count of the incoming block, computed without forming
    // block_size + THREADS_PER_WARP - 1 so the top of the 32-bit range cannot wrap.
    logic [32:0] full_warps;
    logic        partial_warp;
    logic [32:0] nw_raw;
    logic [32:0] nw;

    always_comb begin
        full_warps   = {1'b0, block_size >> TPW_LOG};
        partial_warp = |(block_size & TPW_MASK);
        nw_raw       = full_warps + 33'(partial_warp);
        nw           = (nw_raw > 33'(NUM_WARPS)) ? 33'(NUM_WARPS) : nw_raw;
    end

    // Round-robin pick: scan from active_q+1 upward with wrap. The loop runs from
    // the farthest candidate to the nearest so the nearest pending warp wins.
    logic              sel_found;
    logic [WARP_W-1:0] sel_idx;
    logic [WARP_W-1:0] cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            cand = active_q + k[WARP_W-1:0];
            if (!wdone_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        block_id_d   = block_id_q;
        block_size_d = block_size_q;
        pc_d         = pc_q;
        wdone_d      = wdone_q;
        mem_d        = mem_q;
        ret_d        = ret_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    block_id_d   = block_id;
                    block_size_d = block_size;
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        wdone_d[i] = (33'(i) >= nw);
                        pc_d[i]    = '0;
                    end
                    // Parking on the last warp makes the first scan start at warp 0.
                    active_d = WARP_W'(NUM_WARPS - 1);
                    busy_d   = 1'b1;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    active_d = sel_idx;
                    state_d  = S_FETCH;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (fetch_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Decode results are held for the rest of the instruction.
                mem_d   = mem_req;
                ret_d   = instr_ret;
                state_d = S_REQUEST;
            end
            S_REQUEST: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_q || lsu_done) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                pc_d[active_q] = next_pc;
                if (ret_q) begin
                    wdone_d[active_q] = 1'b1;
                end
                state_d = S_SELECT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            active_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            block_id_q   <= '0;
            block_size_q <= '0;
            wdone_q      <= '0;
            mem_q        <= 1'b0;
            ret_q        <= 1'b0;
            // NOTE: the PC file is reset explicitly; it is only a few words and a
            // reset mid-block must leave every warp restartable from PC 0.
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            block_id_q   <= block_id_d;
            block_size_q <= block_size_d;
            wdone_q      <= wdone_d;
            mem_q        <= mem_d;
            ret_q        <= ret_d;
            pc_q         <= pc_d;
        end
    end

    // The block index is held for the per-warp units; nothing in this block reads it.
    logic unused_block_id;
    assign unused_block_id = ^block_id_q;

    logic        in_stage;
    logic [31:0] thread_base;

    always_comb begin
        in_stage    = (state_q != S_IDLE) && (state_q != S_SELECT);
        warp_enable = in_stage ? (NUM_WARPS'(1) << active_q) : '0;

        case (state_q)
            S_FETCH:   warp_state = W_FETCH;
            S_DECODE:  warp_state = W_DECODE;
            S_REQUEST: warp_state = W_REQUEST;
            S_WAIT:    warp_state = W_WAIT;
            S_EXECUTE: warp_state = W_EXECUTE;
            S_UPDATE:  warp_state = W_UPDATE;
            default:   warp_state = W_IDLE;
        endcase

        // The base thread index never exceeds NUM_WARPS*THREADS_PER_WARP, so the
        // sum below cannot wrap; oversized blocks therefore give full masks.
        thread_base = 32'(active_q) << TPW_LOG;
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
            thread_enable[t] = (thread_base + 32'(t)) < block_size_q;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign active_warp = active_q;
    assign fetch_req   = (state_q == S_FETCH);
    assign fetch_pc    = pc_q[active_q];

endmodule
